// File: rtl/avalon_rr_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-MM slave.
// Whole transfers are serialised and use a waitrequest-only handshake.
// A mandatory IDLE cycle separates grants, so fully loaded masters alternate.
// Optional feature: define ARB_LOCK_EN to add m0_lock/m1_lock inputs. A locked
// master keeps the grant across back-to-back transfers.
module avalon_rr_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e state_q, state_d;
  // Index of the master that completed the most recent transfer; it loses the next tie.
  logic   last_q, last_d;
  logic   req0, req1;
  logic   lock0, lock1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
  assign lock0 = m0_lock;
  assign lock1 = m1_lock;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  // State register with synchronous active-low reset; m0 wins the first tie.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate in IDLE, release on completion or on a dropped request.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? G0 : G1;
        else if (req0)    state_d = G0;
        else if (req1)    state_d = G1;
      end
      G0: begin
        if (!req0) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_d  = 1'b0;
          state_d = lock0 ? G0 : IDLE;
        end
      end
      G1: begin
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_d  = 1'b1;
          state_d = lock1 ? G1 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: combinational mux from the granted master; write masks a simultaneous read.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    unique case (state_q)
      G0: begin
        s_address      = m0_address;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      G1: begin
        s_address      = m1_address;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Self-checking bench for avalon_rr_arbiter: directed scenarios plus a
// randomized run compared against a transfer-level reference model.
// Define ARB_LOCK_EN to also exercise the lock feature.
module tb_avalon_rr_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr  [2];
  logic              rd    [2];
  logic              wr    [2];
  logic [DATA_W-1:0] wdata [2];
  logic [BE_W-1:0]   be    [2];
  logic              lk    [2];
  logic [DATA_W-1:0] rdata [2];
  logic              wreq  [2];
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic [DATA_W-1:0] s_readdata;
  logic              s_waitrequest;

  int checks = 0;
  int errors = 0;

  // Reference model: owner of the slave (-1 = nobody) and last master served.
  int owner  = -1;
  int last_w = 1;

  always #5 clk = ~clk;

  avalon_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .m0_address     (addr[0]),
    .m0_read        (rd[0]),
    .m0_write       (wr[0]),
    .m0_writedata   (wdata[0]),
    .m0_byteenable  (be[0]),
    .m0_readdata    (rdata[0]),
    .m0_waitrequest (wreq[0]),
`ifdef ARB_LOCK_EN
    .m0_lock        (lk[0]),
    .m1_lock        (lk[1]),
`endif
    .m1_address     (addr[1]),
    .m1_read        (rd[1]),
    .m1_write       (wr[1]),
    .m1_writedata   (wdata[1]),
    .m1_byteenable  (be[1]),
    .m1_readdata    (rdata[1]),
    .m1_waitrequest (wreq[1]),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge, updating the model with the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      owner  = -1;
      last_w = 1;
    end else if (owner < 0) begin
      bit r0, r1;
      r0 = rd[0] | wr[0];
      r1 = rd[1] | wr[1];
      if (r0 && r1)  owner = 1 - last_w;
      else if (r0)   owner = 0;
      else if (r1)   owner = 1;
    end else begin
      if (!(rd[owner] | wr[owner])) begin
        owner = -1;
      end else if (!s_waitrequest) begin
        last_w = owner;
        if (!lk[owner]) owner = -1;
      end
    end
    #1;
  endtask

  // Compare every DUT output with what the model owner implies for the present inputs.
  task automatic check_all(input string tag);
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    logic [BE_W-1:0]   e_be;
    logic              e_rd, e_wr, e_w0, e_w1;
    e_addr = '0; e_wd = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0;
    e_w0 = 1'b1; e_w1 = 1'b1;
    if (owner >= 0) begin
      e_addr = addr[owner];
      e_wd   = wdata[owner];
      e_be   = be[owner];
      e_wr   = wr[owner];
      e_rd   = rd[owner] && !wr[owner];
      if (owner == 0) e_w0 = s_waitrequest;
      else            e_w1 = s_waitrequest;
    end
    check({tag, ".s_address"},   64'(s_address),    64'(e_addr));
    check({tag, ".s_read"},      64'(s_read),       64'(e_rd));
    check({tag, ".s_write"},     64'(s_write),      64'(e_wr));
    check({tag, ".s_writedata"}, 64'(s_writedata),  64'(e_wd));
    check({tag, ".s_byteen"},    64'(s_byteenable), 64'(e_be));
    check({tag, ".m0_wait"},     64'(wreq[0]),      64'(e_w0));
    check({tag, ".m1_wait"},     64'(wreq[1]),      64'(e_w1));
    check({tag, ".m0_rdata"},    64'(rdata[0]),     64'(s_readdata));
    check({tag, ".m1_rdata"},    64'(rdata[1]),     64'(s_readdata));
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wdata[i] = '0; be[i] = '0; lk[i] = 1'b0;
    end
    s_readdata    = '0;
    s_waitrequest = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int grant_seen();
    if (!wreq[0]) return 0;
    if (!wreq[1]) return 1;
    return -1;
  endfunction

  initial begin
    int exp_gnt [8];
    exp_gnt = '{0, -1, 1, -1, 0, -1, 1, -1};
    idle_inputs();

    // Reset state
    do_reset();
    check("rst.s_read",  64'(s_read),  64'd0);
    check("rst.s_write", 64'(s_write), 64'd0);
    check("rst.m0_wait", 64'(wreq[0]), 64'd1);
    check("rst.m1_wait", 64'(wreq[1]), 64'd1);

    // Single zero-wait write from m0
    addr[0] = 25'h10; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF; wr[0] = 1'b1;
    tick();
    check("wr1.s_write", 64'(s_write),     64'd1);
    check("wr1.addr",    64'(s_address),   64'h10);
    check("wr1.data",    64'(s_writedata), 64'hDEADBEEF);
    check("wr1.m0_wait", 64'(wreq[0]),     64'd0);
    tick();
    wr[0] = 1'b0;
    #1;
    check("wr2.s_write", 64'(s_write), 64'd0);
    idle_inputs();
    tick();

    // Contention from reset: strict alternation with an IDLE cycle between grants
    do_reset();
    rd[0] = 1'b1; rd[1] = 1'b1; addr[0] = 25'h100; addr[1] = 25'h200;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("cont.gnt%0d", c), 64'(grant_seen()), 64'(exp_gnt[c]));
    end
    idle_inputs();
    tick();
    tick();

    // Slave stall on an m1 read
    rd[1] = 1'b1; addr[1] = 25'h44; s_waitrequest = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall.m1_wait%0d", c), 64'(wreq[1]), 64'd1);
      check($sformatf("stall.m0_wait%0d", c), 64'(wreq[0]), 64'd1);
      check($sformatf("stall.s_read%0d", c),  64'(s_read),  64'd1);
      tick();
    end
    s_waitrequest = 1'b0; s_readdata = 32'h12345678;
    #1;
    check("stall.m1_wait_done", 64'(wreq[1]),  64'd0);
    check("stall.m1_rdata",     64'(rdata[1]), 64'h12345678);
    check("stall.m0_wait_done", 64'(wreq[0]),  64'd1);
    tick();
    idle_inputs();
    tick();

    // Reset aborts a stalled G0 read; m0 then wins the first tie
    rd[0] = 1'b1; addr[0] = 25'h77; s_waitrequest = 1'b1;
    tick();
    check("abort.s_read_before", 64'(s_read), 64'd1);
    rst_n = 1'b0;
    tick();
    check("abort.s_read_after", 64'(s_read), 64'd0);
    rst_n = 1'b1;
    rd[1] = 1'b1; s_waitrequest = 1'b0;
    tick();
    check("abort.tie_gnt", 64'(grant_seen()), 64'd0);
    idle_inputs();
    tick();
    tick();

`ifdef ARB_LOCK_EN
    // Locked m1 runs three back-to-back writes before m0 is served
    wr[1] = 1'b1; lk[1] = 1'b1; addr[1] = 25'h300;
    tick();
    rd[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) lk[1] = 1'b0;
      wdata[1] = 32'(c + 1);
      #1;
      check($sformatf("lock.m1_wait%0d", c), 64'(wreq[1]),     64'd0);
      check($sformatf("lock.m0_wait%0d", c), 64'(wreq[0]),     64'd1);
      check($sformatf("lock.data%0d", c),    64'(s_writedata), 64'(c + 1));
      tick();
    end
    wr[1] = 1'b0;
    #1;
    check("lock.idle_gap", 64'(grant_seen()), -64'sd1);
    tick();
    check("lock.m0_gnt", 64'(grant_seen()), 64'd0);
    idle_inputs();
    tick();
    tick();
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rd[i] = 1'($urandom_range(0, 1));
          wr[i] = ($urandom_range(0, 2) == 0);
`ifdef ARB_LOCK_EN
          lk[i] = ($urandom_range(0, 3) == 0);
`endif
        end
        addr[i]  = ADDR_W'($urandom);
        wdata[i] = $urandom;
        be[i]    = BE_W'($urandom);
      end
      s_waitrequest = 1'($urandom_range(0, 1));
      s_readdata    = $urandom;
      #1;
      check_all($sformatf("rnd%0d", c));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
